audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
- Sink end of the Avalon-ST left/right audio sample streams (16-bit L/R DATA/VALID/READY) produced by the game display/sound engine.
- Buffers each channel in a small FIFO, pairs left and right samples per frame, and serializes them to the board's audio codec DAC in I2S format.
- Generates BCLK and DACLRCK from the 50 MHz system clock; the codec runs in slave mode.

Parameters:
- DATA_W, 16, sample width; must be 16 or less.
- FIFO_DEPTH, 4, entries per channel FIFO; must be a power of 2.
- BCLK_HALF, 8, clk cycles per BCLK half-period. With the defaults, BCLK = 3.125 MHz and fs = 48.83 kHz.

Ports:
- clk  in  1  50 MHz system clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  streaming enable
- L_DATA  in  DATA_W  left sample
- L_VALID  in  1  left sample valid
- L_READY  out  1  left FIFO can accept
- R_DATA  in  DATA_W  right sample
- R_VALID  in  1  right sample valid
- R_READY  out  1  right FIFO can accept
- AUD_BCLK  out  1  bit clock to codec
- AUD_DACLRCK  out  1  word select; 0 = left, 1 = right
- AUD_DACDAT  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse per frame sent without a fresh pair

Behaviour:
- Reset:
  - While reset_n is low, every output is 0 and both FIFOs are empty. The state is IDLE and all counters are 0.
  - Reset mid-frame aborts the frame immediately. Buffered samples are discarded.
- Ready and accept:
  - x_READY = ready_en & !full_x. ready_en is a flop that resets to 0 and sets to 1 one clk after reset release.
  - A transfer happens on a clk edge where VALID & READY are both 1. Data offered while READY=0 is not accepted, and the source holds it.
- Simultaneous push and pop:
  - On a non-full FIFO, occupancy is unchanged.
  - A full FIFO pops with READY=0, so READY returns to 1 on the next clk.
- States:
  - IDLE: AUD_BCLK, AUD_DACLRCK and AUD_DACDAT are held at 0.
    - If enable is 1 and both FIFOs are non-empty, pop one L/R pair into word registers, set slot=0 and div=0, and go to RUN.
  - RUN:
    - div counts 0..BCLK_HALF-1. At the terminal count AUD_BCLK toggles.
    - On each clk edge where AUD_BCLK goes 1->0, slot advances modulo 64.
    - Each slot lasts 2*BCLK_HALF clk; a frame is 64 BCLK.
- Per-slot outputs (s = slot mod 32):
  - AUD_DACLRCK = slot[5].
  - AUD_DACDAT = word_sel[DATA_W - s] for s in 1..DATA_W, otherwise 0. This gives the I2S one-BCLK MSB delay plus zero padding.
  - word_sel is the left word when slot < 32, the right word otherwise.
  - Both outputs are flops updated on the same clk edge as slot. Data changes on BCLK falling edges and is stable at rising edges.
- Frame boundary (slot 63 -> 0):
  - enable = 0: go to IDLE. BCLK stays 0 and the FIFOs are untouched.
  - Else if both FIFOs are non-empty: pop both and load the words.
  - Else: pop neither, load 0 into both words, and pulse underrun for 1 clk. A lone sample in one FIFO is retained, keeping channels paired.
- Latency:
  - The MSB of the first left word appears on AUD_DACDAT 2*BCLK_HALF clk after the IDLE->RUN edge (slot 1).
  - FIFO latency is at least 1 clk: a pushed sample is visible as non-empty on the next clk.
- Arithmetic: slot is 6 bits with natural wrap. div is $clog2(BCLK_HALF) bits. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits for full/empty detection.
- Changing enable mid-frame has no effect until the frame boundary.

Decomposition:
- Shared package audio_pkg holds:
  - DATA_W and the SLOT_BITS=32 / FRAME_BITS=64 constants.
  - The tx_state_t enum {IDLE, RUN}.
- One sub-module: audio_fifo, a synchronous FIFO with push/pop/full/empty/dout. It is instantiated twice, for the left and right channels.

Test Plan:
1. Reset release with enable=0 -> all outputs 0; L_READY and R_READY become 1 one clk after release; AUD_BCLK stays 0.
2. Push L=16'hA5F0 and R=16'h0F0F, then enable=1 -> IDLE->RUN with both FIFOs empty after the pop. Slots 1..16 with LRCK=0 give bits 1010010111110000; slots 17..31 give 0. Slots 33..48 with LRCK=1 give 0000111100001111; underrun stays 0.
3. enable=0, push 5 left samples 1..5 with L_VALID held -> L_READY=0 after the 4th accept and sample 5 is not accepted. Enable (with 4 right samples pushed) -> frames carry left 1,2,3,4 in order, and L_READY rises the clk after the first pop.
4. One pair pushed, enable=1, no further pushes -> frame 2 is all-zero data and underrun pulses exactly 1 clk at the 63->0 boundary, repeating each frame. A push of one left sample only keeps output at zero until the matching right sample arrives.
5. Drop enable at slot 20 -> the frame completes through slot 63; then IDLE with BCLK, LRCK and DACDAT all at 0.
6. Assert reset_n=0 at slot 40 with 3 pairs buffered -> outputs 0 immediately. After release the FIFOs are empty and the first frame waits for new pushes.

Source files
------------

// File: rtl/audio_pkg.sv
// ============================================================================
// Module : audio_pkg
// Brief  : Shared constants and state type for the I2S audio transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned SLOT_W     = $clog2(FRAME_BITS);
    localparam int unsigned SUB_W      = $clog2(SLOT_BITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/audio_fifo.sv
// ============================================================================
// Module : audio_fifo
// Brief  : Synchronous single-clock FIFO with extra pointer bit for full/empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_fifo
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/audio_i2s_tx.sv
// ============================================================================
// Module : audio_i2s_tx
// Brief  : Buffers L/R sample streams and serializes paired frames to an I2S DAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_i2s_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BCLK_HALF  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] L_DATA,
    input  logic              L_VALID,
    output logic              L_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic              R_VALID,
    output logic              R_READY,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              underrun
);

    import audio_pkg::*;

    localparam int unsigned     DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_BITS - 1);

    tx_state_t         state_q, state_d;
    logic              ready_en_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              bclk_q, bclk_d;
    logic              lrck_q, lrck_d;
    logic              dat_q, dat_d;
    logic              und_q, und_d;
    logic [DATA_W-1:0] word_l_q, word_l_d;
    logic [DATA_W-1:0] word_r_q, word_r_d;

    logic              pop;
    logic              full_l, full_r, empty_l, empty_r;
    logic [DATA_W-1:0] dout_l, dout_r;
    logic              both_avail;

    // Sub-slot s carries bit DATA_W-s for s in 1..DATA_W: one-BCLK MSB delay, zero pad after.
    function automatic logic slot_bit(input logic [DATA_W-1:0] w, input logic [SUB_W-1:0] s);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (int'(s) == int'(DATA_W) - i) begin
                b = w[i];
            end
        end
        return b;
    endfunction

    assign L_READY    = ready_en_q & ~full_l;
    assign R_READY    = ready_en_q & ~full_r;
    assign both_avail = ~empty_l & ~empty_r;

    audio_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_l (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (L_VALID & L_READY),
        .din   (L_DATA),
        .pop   (pop),
        .dout  (dout_l),
        .full  (full_l),
        .empty (empty_l)
    );

    audio_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_r (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (R_VALID & R_READY),
        .din   (R_DATA),
        .pop   (pop),
        .dout  (dout_r),
        .full  (full_r),
        .empty (empty_r)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        slot_d   = slot_q;
        bclk_d   = bclk_q;
        lrck_d   = lrck_q;
        dat_d    = dat_q;
        und_d    = 1'b0;
        word_l_d = word_l_q;
        word_r_d = word_r_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                bclk_d = 1'b0;
                lrck_d = 1'b0;
                dat_d  = 1'b0;
                div_d  = '0;
                slot_d = '0;
                if (enable && both_avail) begin
                    pop      = 1'b1;
                    word_l_d = dout_l;
                    word_r_d = dout_r;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // Falling BCLK: advance slot and present its bit and word select.
                    if (bclk_q) begin
                        slot_d = slot_q + SLOT_W'(1);
                        lrck_d = slot_d[SLOT_W-1];
                        dat_d  = slot_bit(slot_d[SLOT_W-1] ? word_r_q : word_l_q,
                                          slot_d[SUB_W-1:0]);
                        if (slot_q == SLOT_LAST) begin
                            if (!enable) begin
                                state_d = IDLE;
                            end else if (both_avail) begin
                                pop      = 1'b1;
                                word_l_d = dout_l;
                                word_r_d = dout_r;
                            end else begin
                                // Lone samples stay queued so L/R remain paired.
                                word_l_d = '0;
                                word_r_d = '0;
                                und_d    = 1'b1;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
            div_q      <= '0;
            slot_q     <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            dat_q      <= 1'b0;
            und_q      <= 1'b0;
            word_l_q   <= '0;
            word_r_q   <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            div_q      <= div_d;
            slot_q     <= slot_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            und_q      <= und_d;
            word_l_q   <= word_l_d;
            word_r_q   <= word_r_d;
        end
    end

    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign underrun    = und_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
// ============================================================================
// Module : tb_audio_i2s_tx
// Brief  : Scoreboard bench for audio_i2s_tx with a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_i2s_tx;

    localparam int DW        = 16;
    localparam int FD        = 4;
    localparam int BH        = 8;
    localparam int SLOT_CLK  = 2 * BH;
    localparam int FRAME_CLK = 64 * SLOT_CLK;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] L_DATA = '0;
    logic          L_VALID = 1'b0;
    logic          L_READY;
    logic [DW-1:0] R_DATA = '0;
    logic          R_VALID = 1'b0;
    logic          R_READY;
    logic          AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun;

    audio_i2s_tx #(.DATA_W(DW), .FIFO_DEPTH(FD), .BCLK_HALF(BH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .L_DATA      (L_DATA),
        .L_VALID     (L_VALID),
        .L_READY     (L_READY),
        .R_DATA      (R_DATA),
        .R_VALID     (R_VALID),
        .R_READY     (R_READY),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .underrun    (underrun)
    );

    initial forever #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level timeline) ----------------
    logic [DW-1:0] mL[$];
    logic [DW-1:0] mR[$];
    logic [31:0]   expq[$];
    bit            m_run = 0;
    int            t = 0;
    bit            m_ren = 0;
    bit            exp_und = 0;
    int            l_acc = 0;
    int            r_acc = 0;
    bit            rl, rr;
    logic [DW-1:0] pl, pr;

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            chk("reset_outputs", {26'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun, L_READY, R_READY}, 32'd0);
            mL.delete(); mR.delete(); expq.delete();
            m_run = 0; t = 0; m_ren = 0; exp_und = 0;
        end else begin
            rl = m_ren && (mL.size() < FD);
            rr = m_ren && (mR.size() < FD);
            chk("L_READY", L_READY, rl);
            chk("R_READY", R_READY, rr);
            chk("underrun", underrun, exp_und);
            if (!m_run) begin
                chk("idle_outputs", {29'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}, 32'd0);
            end else begin
                chk("bclk_phase", AUD_BCLK, (t / BH) % 2);
                chk("lrck_phase", AUD_DACLRCK, t >= FRAME_CLK / 2);
            end
            exp_und = 0;
            // Frame decisions see only samples accepted on earlier edges.
            if (!m_run) begin
                if (enable && mL.size() > 0 && mR.size() > 0) begin
                    pl = mL.pop_front(); pr = mR.pop_front();
                    expq.push_back({pl, pr});
                    m_run = 1; t = 0;
                end
            end else begin
                t++;
                if (t == FRAME_CLK) begin
                    t = 0;
                    if (!enable) begin
                        m_run = 0;
                    end else if (mL.size() > 0 && mR.size() > 0) begin
                        pl = mL.pop_front(); pr = mR.pop_front();
                        expq.push_back({pl, pr});
                    end else begin
                        expq.push_back(32'd0);
                        exp_und = 1;
                    end
                end
            end
            if (rl && L_VALID) begin mL.push_back(L_DATA); l_acc++; end
            if (rr && R_VALID) begin mR.push_back(R_DATA); r_acc++; end
            m_ren = 1;
        end
    end

    // ---------------- sources: hold each sample until accepted ----------------
    logic [DW-1:0] srcL[$];
    logic [DW-1:0] srcR[$];
    int seen_l = 0;
    int seen_r = 0;

    initial forever begin
        @(negedge clk);
        if (l_acc != seen_l) begin seen_l = l_acc; srcL.delete(0); L_VALID = 1'b0; end
        if (!L_VALID && srcL.size() > 0 && $urandom_range(0, 3) != 0) begin
            L_VALID = 1'b1; L_DATA = srcL[0];
        end
    end

    initial forever begin
        @(negedge clk);
        if (r_acc != seen_r) begin seen_r = r_acc; srcR.delete(0); R_VALID = 1'b0; end
        if (!R_VALID && srcR.size() > 0 && $urandom_range(0, 3) != 0) begin
            R_VALID = 1'b1; R_DATA = srcR[0];
        end
    end

    // ---------------- monitor: decode serial frames, pop scoreboard ----------------
    bit mb[64];
    bit ml[64];
    int k = 0;
    int low = 0;
    bit prevb = 0;
    int frames = 0;

    task automatic check_frame();
        logic [DW-1:0] gl = '0;
        logic [DW-1:0] gr = '0;
        logic [31:0]   e;
        bit            fmt_ok = 1;
        int            s;
        for (int i = 0; i < 64; i++) begin
            s = i % 32;
            if (ml[i] != (i >= 32)) fmt_ok = 0;
            if (s >= 1 && s <= DW) begin
                if (i < 32) gl[DW - s] = mb[i];
                else        gr[DW - s] = mb[i];
            end else if (mb[i]) begin
                fmt_ok = 0;
            end
        end
        chk("frame_format", fmt_ok, 1);
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected: got %h/%h expected no frame", gl, gr);
        end else begin
            e = expq.pop_front();
            chk("frame_data", {gl, gr}, e);
        end
        frames++;
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            k = 0; low = 0; prevb = 0;
        end else begin
            if (AUD_BCLK && !prevb) begin
                mb[k] = AUD_DACDAT; ml[k] = AUD_DACLRCK; k++;
                if (k == 64) begin check_frame(); k = 0; end
            end
            if (!AUD_BCLK) begin
                low++;
                if (low > BH) k = 0;
            end else begin
                low = 0;
            end
            prevb = AUD_BCLK;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (m_run && i < 3000) begin @(negedge clk); i++; end
        chk("idle_timeout", m_run, 0);
    endtask

    task automatic wait_slot(input int s);
        int i = 0;
        while (!(m_run && t == s * SLOT_CLK) && i < 3000) begin @(negedge clk); i++; end
        chk("slot_timeout", i < 3000, 1);
    endtask

    task automatic wait_src_empty();
        int i = 0;
        while ((srcL.size() != 0 || srcR.size() != 0) && i < 5000) begin @(negedge clk); i++; end
        chk("source_timeout", i < 5000, 1);
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        srcL.push_back(l);
        srcR.push_back(r);
    endtask

    initial begin
        // Reset and ready release with enable low
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(10);

        // Directed pair, then underrun frames
        push_pair(16'hA5F0, 16'h0F0F);
        wait_src_empty();
        wait_cycles(3);
        enable = 1'b1;
        wait_cycles(3 * FRAME_CLK + 40);
        srcL.push_back(DW'($urandom));
        wait_cycles(FRAME_CLK);
        srcR.push_back(DW'($urandom));
        wait_cycles(2 * FRAME_CLK);
        enable = 1'b0;
        wait_idle();

        // Fill left FIFO past capacity while disabled
        for (int v = 1; v <= 5; v++) srcL.push_back(DW'(v));
        wait_cycles(60);
        for (int v = 0; v < 4; v++) srcR.push_back(DW'($urandom));
        wait_cycles(40);
        enable = 1'b1;
        wait_cycles(5 * FRAME_CLK);
        srcR.push_back(DW'($urandom));
        wait_cycles(FRAME_CLK + 100);
        enable = 1'b0;
        wait_idle();

        // Drop enable mid-frame
        push_pair(DW'($urandom), DW'($urandom));
        wait_src_empty();
        enable = 1'b1;
        wait_slot(20);
        enable = 1'b0;
        wait_idle();
        wait_cycles(100);

        // Reset mid-frame with buffered pairs
        for (int v = 0; v < 4; v++) push_pair(DW'($urandom), DW'($urandom));
        wait_src_empty();
        enable = 1'b1;
        wait_slot(40);
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(300);

        // Randomized traffic
        repeat (12) begin
            int n;
            n = $urandom_range(0, 3);
            for (int v = 0; v < n; v++) push_pair(DW'($urandom), DW'($urandom));
            wait_cycles($urandom_range(200, 1500));
        end
        enable = 1'b0;
        wait_idle();
        wait_cycles(50);

        chk("scoreboard_drained", expq.size(), 0);
        chk("frames_observed", frames >= 15, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
